// File: rtl/bcd_frame_scheduler.sv
// Shares one binary-to-BCD converter among N_VARS display variables. Each frame's inputs are
// snapshotted together, converted one at a time, and the packed results are held until the next frame.
module bcd_frame_scheduler #(
    parameter int N_VARS  = 4,
    parameter int MAX_VAL = 9999,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  frame_start,
    input  logic [16*N_VARS-1:0]  vars,
    output logic                  bcd_load,
    output logic [15:0]           bcd_number,
    input  logic                  bcd_ready,
    input  logic [15:0]           bcd_digits,
    output logic [16*N_VARS-1:0]  bcd_out,
    output logic [N_VARS-1:0]     valid,
    output logic [N_VARS-1:0]     clamped,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);
    localparam int               IDX_W     = (N_VARS > 1) ? $clog2(N_VARS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_VARS - 1);
    localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [15:0]      MAX_NUM   = 16'(MAX_VAL);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_STORE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [16*N_VARS-1:0]  r_snap;
    logic [IDX_W-1:0]      r_idx;
    logic [7:0]            r_wcnt;
    logic [15:0]           w_cur;
    logic                  w_over;
    logic                  w_got;
    logic                  w_tmo;

    always_comb begin
        w_cur = '0;
        for (int i = 0; i < N_VARS; i++) begin
            if (r_idx == IDX_W'(i)) w_cur = r_snap[16*i +: 16];
        end
    end

    assign w_over = (w_cur > MAX_NUM);
    // The first WAIT cycle (count 0) may still see a ready level left over from the previous result.
    assign w_got  = bcd_ready && (r_wcnt != 8'd0);
    assign w_tmo  = (r_wcnt == WAIT_LAST);
    assign busy   = (r_state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        bcd_load   = 1'b0;
        bcd_number = '0;
        done       = 1'b0;
        case (r_state)
            S_IDLE:  if (frame_start) w_next = S_LOAD;
            S_LOAD: begin
                bcd_load   = 1'b1;
                bcd_number = w_over ? MAX_NUM : w_cur;
                w_next     = S_WAIT;
            end
            S_WAIT:  if (w_got || w_tmo) w_next = S_STORE;
            S_STORE: begin
                if (r_idx == LAST_IDX) begin
                    done   = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_LOAD;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap  <= '0;
            r_idx   <= '0;
            r_wcnt  <= '0;
            bcd_out <= '0;
            valid   <= '0;
            clamped <= '0;
            overrun <= 1'b0;
        end else begin
            if (frame_start && busy) overrun <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_snap <= vars;
                        r_idx  <= '0;
                    end
                end
                S_LOAD: begin
                    r_wcnt <= '0;
                    for (int i = 0; i < N_VARS; i++) begin
                        if (r_idx == IDX_W'(i)) clamped[i] <= w_over;
                    end
                end
                S_WAIT: begin
                    r_wcnt <= r_wcnt + 8'd1;
                    for (int i = 0; i < N_VARS; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            if (w_got) begin
                                bcd_out[16*i +: 16] <= bcd_digits;
                                valid[i]            <= 1'b1;
                            end else if (w_tmo) begin
                                valid[i]            <= 1'b0;
                            end
                        end
                    end
                end
                S_STORE: begin
                    if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_frame_scheduler.sv
// Bench for bcd_frame_scheduler: a converter model reacts to bcd_load, and a frame-level timeline model predicts every output each cycle.
module tb_bcd_frame_scheduler;
    localparam int NV = 3;
    localparam int MX = 9999;
    localparam int TO = 20;

    logic             clk = 1'b0;
    logic             reset;
    logic             frame_start;
    logic [16*NV-1:0] vars;
    logic             bcd_load;
    logic [15:0]      bcd_number;
    logic             bcd_ready;
    logic [15:0]      bcd_digits;
    logic [16*NV-1:0] bcd_out;
    logic [NV-1:0]    valid;
    logic [NV-1:0]    clamped;
    logic             busy;
    logic             done;
    logic             overrun;

    bcd_frame_scheduler #(.N_VARS(NV), .MAX_VAL(MX), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .vars(vars),
        .bcd_load(bcd_load), .bcd_number(bcd_number), .bcd_ready(bcd_ready),
        .bcd_digits(bcd_digits), .bcd_out(bcd_out), .valid(valid), .clamped(clamped),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Frame timeline model: each slot is LOAD, w WAIT cycles, STORE; w is the ready cycle or TO.
    bit          m_active = 1'b0;
    int          m_L[NV];
    int          m_S[NV];
    int          m_d[NV];
    bit          m_g[NV];
    bit          m_ok[NV];
    logic [15:0] m_snap[NV];
    logic [15:0] e_out[NV];
    bit          e_valid[NV];
    bit          e_clamp[NV];
    int          ovr_at = -1;
    int          nd[NV];
    bit          ng[NV];

    int          cv_ld = -100;
    int          cv_d  = 0;
    int          cv_n  = 0;
    bit          cv_g  = 1'b0;
    bit          cv_on = 1'b0;
    logic [15:0] cv_num = '0;
    logic [15:0] ld_log[$];
    int          done_log[$];

    logic [16*NV-1:0] ev_out;
    logic [NV-1:0]    ev_val;
    logic [NV-1:0]    ev_clp;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    function automatic int clampv(input logic [15:0] v);
        return (int'(v) > MX) ? MX : int'(v);
    endfunction

    function automatic bit m_busy(input int c);
        return m_active && (c >= m_L[0]) && (c <= m_S[NV-1]);
    endfunction

    function automatic logic [15:0] rand_val();
        case ($urandom % 5)
            0: return 16'($urandom_range(0, 9999));
            1: return 16'($urandom_range(9990, 10010));
            2: return 16'($urandom_range(0, 65535));
            3: return 16'($urandom_range(0, 99));
            default: return ($urandom % 2 == 0) ? 16'hFFFF : 16'd10000;
        endcase
    endfunction

    task automatic model_start(input int t);
        int l;
        l = t + 1;
        m_active = 1'b1;
        for (int i = 0; i < NV; i++) begin
            int w;
            m_snap[i] = vars[16*i +: 16];
            m_d[i]    = nd[i];
            m_g[i]    = ng[i];
            m_ok[i]   = (nd[i] >= 2) && (nd[i] <= TO);
            w         = m_ok[i] ? nd[i] : TO;
            m_L[i]    = l;
            m_S[i]    = l + w + 1;
            l         = m_S[i] + 1;
        end
        cv_n = 0;
    endtask

    task automatic model_clear();
        m_active = 1'b0;
        ovr_at   = -1;
        for (int i = 0; i < NV; i++) begin
            e_out[i]   = '0;
            e_valid[i] = 1'b0;
            e_clamp[i] = 1'b0;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Converter model: latches operand on load, raises ready at WAIT cycle d, optionally a stale ready in WAIT cycle 1.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            cv_on = 1'b0;
        end else begin
            if (bcd_load) begin
                cv_on  = 1'b1;
                cv_ld  = cyc;
                cv_num = bcd_number;
                cv_d   = (cv_n < NV) ? m_d[cv_n] : 0;
                cv_g   = (cv_n < NV) ? m_g[cv_n] : 1'b0;
                cv_n++;
                ld_log.push_back(bcd_number);
            end
            if (done) done_log.push_back(cyc);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        bcd_ready  = cv_on && ((cv_d > 0 && cyc == cv_ld + cv_d) || (cv_g && cyc == cv_ld + 1));
        bcd_digits = to_bcd(int'(cv_num));
    end

    // Per-cycle comparison against the timeline model.
    initial forever begin
        bit          exp_load;
        logic [15:0] exp_num;
        @(negedge clk);
        if (reset) begin
            model_clear();
            chk("rst_number", bcd_number, 0);
        end else if (m_active) begin
            for (int i = 0; i < NV; i++) begin
                if (cyc == m_L[i] + 1) e_clamp[i] = (int'(m_snap[i]) > MX);
                if (cyc == m_S[i]) begin
                    e_valid[i] = m_ok[i];
                    if (m_ok[i]) e_out[i] = to_bcd(clampv(m_snap[i]));
                end
            end
        end
        exp_load = 1'b0;
        exp_num  = '0;
        for (int i = 0; i < NV; i++) begin
            if (m_active && cyc == m_L[i]) begin
                exp_load = 1'b1;
                exp_num  = 16'(clampv(m_snap[i]));
            end
            ev_out[16*i +: 16] = e_out[i];
            ev_val[i]          = e_valid[i];
            ev_clp[i]          = e_clamp[i];
        end
        chk("bcd_load", bcd_load, exp_load);
        if (exp_load) chk("bcd_number", bcd_number, exp_num);
        chk("busy", busy, m_busy(cyc));
        chk("done", done, m_active && cyc == m_S[NV-1]);
        chk("overrun", overrun, (ovr_at >= 0) && (cyc >= ovr_at));
        chk("bcd_out", bcd_out, ev_out);
        chk("valid", valid, ev_val);
        chk("clamped", clamped, ev_clp);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        if (m_busy(cyc)) begin
            if (ovr_at < 0) ovr_at = cyc + 1;
        end else begin
            model_start(cyc);
        end
        step();
        frame_start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || m_busy(cyc)) && n < 2000) begin
            step();
            n++;
        end
        chk("wait_idle_bound", (n < 2000), 1);
    endtask

    task automatic set_conv(input int d, input bit g);
        for (int i = 0; i < NV; i++) begin
            nd[i] = d;
            ng[i] = g;
        end
    endtask

    int t0;

    initial begin
        reset = 1'b1; frame_start = 1'b0; vars = '0; bcd_ready = 1'b0; bcd_digits = '0;
        model_clear();
        repeat (3) step();
        chk("rst_out", {bcd_out, valid, clamped, busy, done, overrun, bcd_load}, 0);
        reset = 1'b0;
        step();

        // Three-slot frame, ready 18 cycles after load.
        set_conv(18, 1'b0);
        vars = {16'd42, 16'd9999, 16'd0};
        ld_log.delete(); done_log.delete();
        t0 = cyc;
        pulse_fs();
        wait_idle();
        chk("a_nload", ld_log.size(), 3);
        chk("a_op0", ld_log[0], 16'h0000);
        chk("a_op1", ld_log[1], 16'h270F);
        chk("a_op2", ld_log[2], 16'h002A);
        chk("a_out", bcd_out, 48'h0042_9999_0000);
        chk("a_valid", valid, 3'b111);
        chk("a_ndone", done_log.size(), 1);
        chk("a_done_cyc", done_log[0], t0 + 60);

        // Clamping, started in the cycle right after done.
        nd[0] = 3; nd[1] = 4; nd[2] = 5;
        vars = {16'd7, 16'd65535, 16'd12345};
        ld_log.delete(); done_log.delete();
        pulse_fs();
        wait_idle();
        chk("b_op0", ld_log[0], 16'h270F);
        chk("b_clamped", clamped, 3'b011);
        chk("b_out", bcd_out, 48'h0007_9999_9999);
        chk("b_valid", valid, 3'b111);

        // Converter never ready: all slots time out, old results held.
        set_conv(0, 1'b0);
        ng[1] = 1'b1;
        vars = {16'd1, 16'd2, 16'd3};
        ld_log.delete(); done_log.delete();
        t0 = cyc;
        pulse_fs();
        wait_idle();
        chk("c_valid", valid, 3'b000);
        chk("c_out_held", bcd_out, 48'h0007_9999_9999);
        chk("c_ndone", done_log.size(), 1);
        chk("c_done_cyc", done_log[0], t0 + 66);
        chk("c_no_overrun", overrun, 1'b0);

        // Overrun and input coherence.
        set_conv(6, 1'b0);
        vars = {16'd300, 16'd200, 16'd100};
        ld_log.delete();
        pulse_fs();
        repeat (5) step();
        vars = {16'd1111, 16'd2222, 16'd3333};
        pulse_fs();
        vars = {16'd4444, 16'd5555, 16'd6666};
        wait_idle();
        chk("d_overrun", overrun, 1'b1);
        chk("d_nload", ld_log.size(), 3);
        chk("d_out", bcd_out, 48'h0300_0200_0100);

        // Reset while waiting on the converter.
        set_conv(10, 1'b0);
        vars = {16'd1, 16'd2, 16'd3};
        pulse_fs();
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("e_rst_outs", {bcd_out, valid, clamped, busy, done, overrun, bcd_load, bcd_number}, 0);
        step();
        reset = 1'b0;
        done_log.delete();
        repeat (30) step();
        chk("e_no_done", done_log.size(), 0);
        set_conv(2, 1'b0);
        vars = {16'd9, 16'd8, 16'd7};
        pulse_fs();
        wait_idle();
        chk("e_out", bcd_out, 48'h0009_0008_0007);
        chk("e_valid", valid, 3'b111);

        // Level ready still high in the first WAIT cycle.
        set_conv(5, 1'b1);
        vars = {16'd55, 16'd66, 16'd77};
        done_log.delete();
        t0 = cyc;
        pulse_fs();
        wait_idle();
        chk("f_done_cyc", done_log[0], t0 + 21);
        chk("f_out", bcd_out, 48'h0055_0066_0077);

        // Randomized frames with overlapping starts, input churn and occasional resets.
        for (int k = 0; k < 150; k++) begin
            int gap;
            gap = $urandom_range(0, 60);
            for (int s = 0; s < gap; s++) begin
                if ($urandom % 2 == 0) vars = {rand_val(), rand_val(), rand_val()};
                step();
            end
            if ($urandom % 25 == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 2)) step();
                reset = 1'b0;
                step();
            end
            for (int i = 0; i < NV; i++) begin
                nd[i] = $urandom_range(0, TO + 2);
                ng[i] = ($urandom % 3 == 0);
            end
            vars = {rand_val(), rand_val(), rand_val()};
            pulse_fs();
        end
        wait_idle();
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
